// File: rtl/cache_2way_through_if.sv
// ============================================================================
//  Module      : cache_2way_through_if
//  Description : Bus bundle for cache_2way_through. Carries the CPU request /
//                completion signals and the block interface to MainMemory.
//                Port summary:
//                  cpu_req, cpu_read_write, cpu_address[9:0],
//                  cpu_write_data[31:0]                -> into the cache
//                  cpu_read_data[31:0], cpu_hit,
//                  cpu_done, busy                      <- from the cache
//                  mem_read_write, mem_address[9:0],
//                  mem_write_data[127:0]               <- from the cache
//                  mem_read_data[127:0]                -> into the cache
//                The slave modport is the cache's view. The master modport
//                is the environment's view (CPU plus MainMemory).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cache_2way_through_if;
  logic         cpu_req;
  logic         cpu_read_write;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         cpu_hit;
  logic         cpu_done;
  logic         busy;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;

  modport slave (
    input  cpu_req, cpu_read_write, cpu_address, cpu_write_data, mem_read_data,
    output cpu_read_data, cpu_hit, cpu_done, busy,
           mem_read_write, mem_address, mem_write_data
  );

  modport master (
    output cpu_req, cpu_read_write, cpu_address, cpu_write_data, mem_read_data,
    input  cpu_read_data, cpu_hit, cpu_done, busy,
           mem_read_write, mem_address, mem_write_data
  );
endinterface

`default_nettype wire

// File: rtl/cache_2way_through.sv
// ============================================================================
//  Module      : cache_2way_through
//  Description : 2-way set-associative, write-through, write-no-allocate
//                cache. 2 sets x 2 ways x 4-word lines, 10-bit byte address
//                (offset=[3:2], index=[4], tag=[9:5]). Misses fetch a
//                128-bit block from a combinational MainMemory. Every write
//                is forwarded to memory as a single word.
//                Ports:
//                  clk   - rising-edge clock
//                  reset - synchronous, active-high
//                  bus   - cache_2way_through_if.slave (CPU and memory side)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_2way_through #(
  parameter int MEM_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  cache_2way_through_if.slave     bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2,
    S_WMEM   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               rw_q, rw_d;
  logic [9:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               hitflag_q, hitflag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               valid_q [2][2];
  logic               valid_d [2][2];
  logic [4:0]         tag_q   [2][2];
  logic [4:0]         tag_d   [2][2];
  logic [31:0]        data_q  [2][2][4];
  logic [31:0]        data_d  [2][2][4];
  logic               lru_q   [2];
  logic               lru_d   [2];

  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mrw_q, mrw_d;
  logic [9:0]         maddr_q, maddr_d;
  logic [127:0]       mwdata_q, mwdata_d;

  // Decode of the latched request and tag compare against both ways.
  logic               set_sel;
  logic [4:0]         tag_sel;
  logic [1:0]         off_sel;
  logic               hit0, hit1, any_hit, hit_way, victim;
  logic [127:0]       fill_shift;

  assign set_sel    = addr_q[4];
  assign tag_sel    = addr_q[9:5];
  assign off_sel    = addr_q[3:2];
  assign hit0       = valid_q[set_sel][0] && (tag_q[set_sel][0] == tag_sel);
  assign hit1       = valid_q[set_sel][1] && (tag_q[set_sel][1] == tag_sel);
  assign any_hit    = hit0 || hit1;
  assign hit_way    = hit1;
  // Fill empty ways first (way0 before way1), otherwise replace the LRU way.
  assign victim     = !valid_q[set_sel][0] ? 1'b0 :
                      !valid_q[set_sel][1] ? 1'b1 : lru_q[set_sel];
  // Moves word[offset] of the incoming block to the top lane.
  assign fill_shift = bus.mem_read_data << {off_sel, 5'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hitflag_q <= 1'b0;
      cnt_q     <= '0;
      for (int s = 0; s < 2; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          for (int k = 0; k < 4; k++) data_q[s][w][k] <= '0;
        end
      end
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      mrw_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hitflag_q <= hitflag_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      lru_q     <= lru_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      rdata_q   <= rdata_d;
      mrw_q     <= mrw_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hitflag_d = hitflag_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    lru_d     = lru_q;
    done_d    = 1'b0;
    hit_d     = hit_q;
    rdata_d   = rdata_q;
    mrw_d     = mrw_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          state_d = S_LOOKUP;
          rw_d    = bus.cpu_read_write;
          addr_d  = bus.cpu_address;
          wdata_d = bus.cpu_write_data;
          // Writes always reach memory: present address and data now, while
          // mem_read_write is still 0, so that it rises later with both stable.
          if (bus.cpu_read_write) begin
            maddr_d  = bus.cpu_address;
            mwdata_d = {bus.cpu_write_data, 96'b0} >> {bus.cpu_address[3:2], 5'b0};
          end
        end
      end

      S_LOOKUP: begin
        cnt_d = '0;
        if (!rw_q) begin
          if (any_hit) begin
            state_d          = S_IDLE;
            done_d           = 1'b1;
            hit_d            = 1'b1;
            rdata_d          = data_q[set_sel][hit_way][off_sel];
            lru_d[set_sel]   = ~hit_way;
          end else begin
            state_d = S_FILL;
            maddr_d = addr_q;
          end
        end else begin
          if (any_hit) begin
            data_d[set_sel][hit_way][off_sel] = wdata_q;
            lru_d[set_sel]                    = ~hit_way;
          end
          hitflag_d = any_hit;
          mrw_d     = 1'b1;
          state_d   = S_WMEM;
        end
      end

      S_FILL: begin
        if (cnt_q == CNT_LAST) begin
          for (int k = 0; k < 4; k++) begin
            data_d[set_sel][victim][k] = bus.mem_read_data[127 - 32*k -: 32];
          end
          valid_d[set_sel][victim] = 1'b1;
          tag_d[set_sel][victim]   = tag_sel;
          lru_d[set_sel]           = ~victim;
          state_d                  = S_IDLE;
          done_d                   = 1'b1;
          hit_d                    = 1'b0;
          rdata_d                  = fill_shift[127:96];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WMEM: begin
        if (cnt_q == CNT_LAST) begin
          mrw_d   = 1'b0;
          state_d = S_IDLE;
          done_d  = 1'b1;
          hit_d   = hitflag_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cpu_read_data  = rdata_q;
  assign bus.cpu_hit        = hit_q;
  assign bus.cpu_done       = done_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.mem_read_write = mrw_q;
  assign bus.mem_address    = maddr_q;
  assign bus.mem_write_data = mwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_2way_through.sv
// ============================================================================
//  Module      : tb_cache_2way_through
//  Description : Self-checking bench for cache_2way_through. Holds a
//                combinational MainMemory (mem[i]=i+1), a reference memory
//                image and an LRU cache-occupancy model built from access
//                timestamps.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_2way_through;

  localparam int ML = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_2way_through_if bus();

  cache_2way_through #(.MEM_LATENCY(ML)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- MainMemory ----------------
  logic [31:0]  mem    [256];
  logic [31:0]  refmem [256];
  logic [127:0] wr_shift;

  always_comb begin
    bus.mem_read_data = '0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_read_data[127 - 32*k -: 32] = mem[{bus.mem_address[9:4], 2'(k)}];
    end
  end

  assign wr_shift = bus.mem_write_data << {bus.mem_address[3:2], 5'b0};

  always @(posedge clk) begin
    if (bus.mem_read_write) mem[bus.mem_address[9:2]] <= wr_shift[127:96];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each set holds up to two tags; on a miss the oldest-used one is replaced.
  bit          mval [2][2];
  logic [4:0]  mtag [2][2];
  int unsigned muse [2][2];
  int unsigned now_t = 0;

  task automatic model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 2; i++) begin
        mval[s][i] = 0;
        muse[s][i] = 0;
      end
  endtask

  task automatic model_access(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                              output bit hit);
    int s, slot, v;
    s    = int'(a[4]);
    slot = -1;
    for (int i = 0; i < 2; i++)
      if (mval[s][i] && mtag[s][i] == a[9:5]) slot = i;
    hit = (slot >= 0);
    now_t++;
    if (hit) begin
      muse[s][slot] = now_t;
    end else if (!rw) begin
      if (!mval[s][0])      v = 0;
      else if (!mval[s][1]) v = 1;
      else                  v = (muse[s][0] < muse[s][1]) ? 0 : 1;
      mval[s][v] = 1;
      mtag[s][v] = a[9:5];
      muse[s][v] = now_t;
    end
    if (rw) refmem[a[9:2]] = wd;
  endtask

  // ---------------- transaction driver ----------------
  // Entered and left on a falling edge. With spam set, a bogus write is held
  // on the request lines while the cache is busy; it must be ignored.
  task automatic do_req(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                        input bit spam, output logic [31:0] rd, output logic hit_o);
    bit   exp_hit;
    int   exp_lat, n;
    model_access(rw, a, wd, exp_hit);
    exp_lat = (!rw && exp_hit) ? 1 : 1 + ML;

    chk("idle_before_req", {127'b0, bus.busy}, 128'd0);
    bus.cpu_req        = 1'b1;
    bus.cpu_read_write = rw;
    bus.cpu_address    = a;
    bus.cpu_write_data = wd;
    @(negedge clk);
    chk("busy_after_accept", {127'b0, bus.busy}, 128'd1);
    if (spam) begin
      bus.cpu_read_write = 1'b1;
      bus.cpu_address    = 10'h3FC;
      bus.cpu_write_data = 32'hBAD0BAD0;
    end else begin
      bus.cpu_req = 1'b0;
    end
    n = 0;
    while (!bus.cpu_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.cpu_req = 1'b0;
    rd    = bus.cpu_read_data;
    hit_o = bus.cpu_hit;
    chk("latency", 128'(n), 128'(exp_lat));
    chk("hit", {127'b0, bus.cpu_hit}, {127'b0, exp_hit});
    chk("busy_at_done", {127'b0, bus.busy}, 128'd0);
    if (!rw) chk("read_data", {96'b0, bus.cpu_read_data}, {96'b0, refmem[a[9:2]]});
    else     chk("mem_word", {96'b0, mem[a[9:2]]}, {96'b0, refmem[a[9:2]]});
    @(negedge clk);
    chk("done_pulse", {127'b0, bus.cpu_done}, 128'd0);
    chk("mrw_idle", {127'b0, bus.mem_read_write}, 128'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        h;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'(i + 1);
      refmem[i] = 32'(i + 1);
    end
    model_clear();
    reset              = 1'b1;
    bus.cpu_req        = 1'b0;
    bus.cpu_read_write = 1'b0;
    bus.cpu_address    = '0;
    bus.cpu_write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {127'b0, bus.busy},           128'd0);
    chk("rst_done",   {127'b0, bus.cpu_done},       128'd0);
    chk("rst_hit",    {127'b0, bus.cpu_hit},        128'd0);
    chk("rst_rdata",  {96'b0, bus.cpu_read_data},   128'd0);
    chk("rst_mrw",    {127'b0, bus.mem_read_write}, 128'd0);
    chk("rst_maddr",  {118'b0, bus.mem_address},    128'd0);
    chk("rst_mwdata", bus.mem_write_data,           128'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios with values fixed by the memory preload.
    do_req(1'b0, 10'h000, 32'h0, 1'b0, rd, h);
    chk("t1_data", {96'b0, rd}, 128'h1);
    do_req(1'b0, 10'h00C, 32'h0, 1'b0, rd, h);
    chk("t2_data", {96'b0, rd}, 128'h4);
    chk("t2_hit", {127'b0, h}, 128'd1);
    do_req(1'b1, 10'h008, 32'hDEADBEEF, 1'b0, rd, h);
    chk("t3_hit", {127'b0, h}, 128'd1);
    chk("t3_mem", {96'b0, mem[2]}, 128'hDEADBEEF);
    do_req(1'b0, 10'h008, 32'h0, 1'b0, rd, h);
    chk("t3_read", {96'b0, rd}, 128'hDEADBEEF);
    do_req(1'b0, 10'h000, 32'h0, 1'b0, rd, h);
    do_req(1'b0, 10'h020, 32'h0, 1'b1, rd, h);
    do_req(1'b0, 10'h040, 32'h0, 1'b0, rd, h);
    do_req(1'b0, 10'h000, 32'h0, 1'b0, rd, h);
    chk("t4_evicted", {127'b0, h}, 128'd0);
    do_req(1'b0, 10'h040, 32'h0, 1'b0, rd, h);
    chk("t4_data", {96'b0, rd}, 128'h11);
    chk("t4_hit", {127'b0, h}, 128'd1);
    do_req(1'b1, 10'h100, 32'h12345678, 1'b1, rd, h);
    chk("t5_hit", {127'b0, h}, 128'd0);
    do_req(1'b0, 10'h100, 32'h0, 1'b0, rd, h);
    chk("t5_miss", {127'b0, h}, 128'd0);
    chk("t5_data", {96'b0, rd}, 128'h12345678);

    // Reset while a fill is in progress.
    bus.cpu_req        = 1'b1;
    bus.cpu_read_write = 1'b0;
    bus.cpu_address    = 10'h080;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("t6_busy_fill", {127'b0, bus.busy}, 128'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", {127'b0, bus.busy},           128'd0);
    chk("t6_done", {127'b0, bus.cpu_done},       128'd0);
    chk("t6_mrw",  {127'b0, bus.mem_read_write}, 128'd0);
    model_clear();
    do_req(1'b0, 10'h040, 32'h0, 1'b0, rd, h);
    chk("t6_remiss", {127'b0, h}, 128'd0);

    // Random traffic over a small tag range to exercise hits and evictions.
    for (int i = 0; i < 300; i++) begin
      logic [9:0]  a;
      logic        rw;
      a  = {5'($urandom_range(0, 3)), 1'($urandom), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) a = 10'($urandom);
      rw = ($urandom_range(0, 9) < 3);
      do_req(rw, a, $urandom, ($urandom_range(0, 3) == 0), rd, h);
    end

    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== refmem[i]) chk("final_mem", {96'b0, mem[i]}, {96'b0, refmem[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
